// File: rtl/rv32_pkg.sv
// Shared load/store types and helpers: funct3 encodings, LSU FSM states and
// the size/alignment rules used by both the controller and the lane aligner.
package rv32_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // Byte mask of the access size; unlisted funct3 codes behave as a word.
    function automatic logic [3:0] size_mask(input logic [2:0] op);
        logic [3:0] m;
        case (op)
            LSU_B, LSU_BU: m = 4'b0001;
            LSU_H, LSU_HU: m = 4'b0011;
            default:       m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            LSU_B, LSU_BU: mis = 1'b0;
            LSU_H, LSU_HU: mis = (off == 2'd3);
            default:       mis = (off != 2'd0);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: per-beat byte enables and shifted store data,
// plus the two-word load merge with sign/zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic        beat,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [4:0]  byte_sh;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [31:0] rd_sh;

    // Shifting into a double-width vector gives beat 0 in the low half and the
    // spill-over for beat 1 in the high half without a separate right shift.
    always_comb begin
        byte_sh    = {off, 3'b000};
        be_wide    = {4'b0000, size_mask(op)} << off;
        wd_wide    = {32'h0, wdata} << byte_sh;
        be         = beat ? be_wide[7:4] : be_wide[3:0];
        wdata_lane = beat ? wd_wide[63:32] : wd_wide[31:0];
        rd_sh      = 32'({rdata1, rdata0} >> byte_sh);
        case (op)
            LSU_B:   load_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
            LSU_BU:  load_data = {24'h0, rd_sh[7:0]};
            LSU_H:   load_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
            LSU_HU:  load_data = {16'h0, rd_sh[15:0]};
            default: load_data = rd_sh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: accepts one core request, runs one or two
// req/gnt/rvalid beats on the data bus and returns extended load data.
module lsu_ctrl
    import rv32_pkg::*;
#(
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic        i_mem_rw,
    input  logic [2:0]  i_lsu_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_rsp_vld,
    output logic [31:0] o_rdata,
    output logic        o_misalign_err,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    output lsu_state_e  o_dbg_state
);

    // Handshakes: a core request transfers on a cycle where i_req_vld && o_req_rdy;
    // a bus beat is granted on a cycle where o_bus_req && i_bus_gnt, and its
    // completion is the first i_bus_rvalid seen in the following WAIT state.

    lsu_state_e  state_q, state_d;
    logic        rw_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic        split_q;
    logic        err_q;

    logic        accept;
    logic        req_mis;
    logic        beat;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign accept  = (state_q == IDLE) && i_req_vld;
    assign req_mis = is_misaligned(i_lsu_op, i_addr[1:0]);
    assign beat    = (state_q == REQ1);

    lsu_align u_align (
        .op         (op_q),
        .off        (addr_q[1:0]),
        .beat       (beat),
        .wdata      (wdata_q),
        .rdata0     (rdata0_q),
        .rdata1     (rdata1_q),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rw_q     <= MEM_RD;
            op_q     <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rw_q     <= i_mem_rw;
                op_q     <= i_lsu_op;
                addr_q   <= i_addr;
                wdata_q  <= i_wdata;
                rdata0_q <= 32'h0;
                rdata1_q <= 32'h0;
                split_q  <= req_mis && ALLOW_MISALIGN;
                err_q    <= req_mis && !ALLOW_MISALIGN;
            end
            if ((state_q == WAIT0) && i_bus_rvalid) begin
                rdata0_q <= i_bus_rdata;
            end
            if ((state_q == WAIT1) && i_bus_rvalid) begin
                rdata1_q <= i_bus_rdata;
            end
        end
    end

    // A rejected misaligned access passes through REQ0 with the bus request
    // masked, so its response arrives two cycles after acceptance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req_vld) state_d = REQ0;
            REQ0: begin
                if (err_q)          state_d = RESP;
                else if (i_bus_gnt) state_d = WAIT0;
            end
            WAIT0:   if (i_bus_rvalid) state_d = split_q ? REQ1 : RESP;
            REQ1:    if (i_bus_gnt) state_d = WAIT1;
            WAIT1:   if (i_bus_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_rdy      = (state_q == IDLE);
        o_bus_req      = ((state_q == REQ0) && !err_q) || (state_q == REQ1);
        o_bus_we       = 1'b0;
        o_bus_addr     = 32'h0;
        o_bus_be       = 4'b0000;
        o_bus_wdata    = 32'h0;
        o_rsp_vld      = (state_q == RESP);
        o_rdata        = 32'h0;
        o_misalign_err = 1'b0;
        o_dbg_state    = state_q;
        if (o_bus_req) begin
            o_bus_we    = (rw_q == MEM_WR);
            o_bus_addr  = {addr_q[31:2] + {29'h0, beat}, 2'b00};
            o_bus_be    = lane_be;
            o_bus_wdata = lane_wdata;
        end
        if (state_q == RESP) begin
            o_misalign_err = err_q;
            if ((rw_q == MEM_RD) && !err_q) o_rdata = load_data;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one split-capable instance and one that
// rejects misaligned accesses, both driven from a single stimulus sequence.
module tb_lsu_ctrl;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_vld = 1'b0, req_vld1 = 1'b0;
    logic        mem_rw = 1'b0;
    logic [2:0]  lsu_op = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;

    logic        d0_req_rdy, d0_rsp_vld, d0_err, d0_bus_req, d0_bus_we;
    logic [31:0] d0_rdata, d0_bus_addr, d0_bus_wdata;
    logic [3:0]  d0_bus_be;
    lsu_state_e  d0_state;
    logic        d1_req_rdy, d1_rsp_vld, d1_err, d1_bus_req, d1_bus_we;
    logic [31:0] d1_rdata, d1_bus_addr, d1_bus_wdata;
    logic [3:0]  d1_bus_be;
    lsu_state_e  d1_state;

    int total = 0, bad = 0;
    int cyc = 0, acc_cyc = 0;
    logic [31:0] exp_q[$];

    lsu_ctrl #(.ALLOW_MISALIGN(1'b1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld), .o_req_rdy(d0_req_rdy),
        .i_mem_rw(mem_rw), .i_lsu_op(lsu_op), .i_addr(addr), .i_wdata(wdata),
        .o_rsp_vld(d0_rsp_vld), .o_rdata(d0_rdata), .o_misalign_err(d0_err),
        .o_bus_req(d0_bus_req), .i_bus_gnt(gnt), .o_bus_we(d0_bus_we),
        .o_bus_addr(d0_bus_addr), .o_bus_be(d0_bus_be), .o_bus_wdata(d0_bus_wdata),
        .i_bus_rvalid(rvalid), .i_bus_rdata(rdata), .o_dbg_state(d0_state)
    );

    lsu_ctrl #(.ALLOW_MISALIGN(1'b0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(req_vld1), .o_req_rdy(d1_req_rdy),
        .i_mem_rw(mem_rw), .i_lsu_op(lsu_op), .i_addr(addr), .i_wdata(wdata),
        .o_rsp_vld(d1_rsp_vld), .o_rdata(d1_rdata), .o_misalign_err(d1_err),
        .o_bus_req(d1_bus_req), .i_bus_gnt(gnt), .o_bus_we(d1_bus_we),
        .o_bus_addr(d1_bus_addr), .o_bus_be(d1_bus_be), .o_bus_wdata(d1_bus_wdata),
        .i_bus_rvalid(rvalid), .i_bus_rdata(rdata), .o_dbg_state(d1_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drivers: every task starts and ends 1 time unit after a rising edge.
    task automatic issue(input bit sel, input logic rw, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_rw = rw; lsu_op = op; addr = a; wdata = wd;
        if (sel) req_vld1 = 1'b1; else req_vld = 1'b1;
        mid();
        chk("req_rdy", 32'(sel ? d1_req_rdy : d0_req_rdy), 32'd1);
        acc_cyc = cyc;
        tick();
        req_vld = 1'b0; req_vld1 = 1'b0;
        mem_rw = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
    endtask

    task automatic bus_beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                            input logic ewe, input logic [31:0] ewd, input logic [31:0] rd,
                            input int gnt_wait);
        for (int i = 0; i <= gnt_wait; i++) begin
            if (i == gnt_wait) gnt = 1'b1;
            mid();
            chk({tag, "_req"}, 32'(d0_bus_req), 32'd1);
            chk({tag, "_addr"}, d0_bus_addr, ea);
            chk({tag, "_be_we"}, {27'h0, ewe, d0_bus_be}, {27'h0, ewe, ebe});
            if (i == 0) begin
                chk({tag, "_we"}, 32'(d0_bus_we), 32'(ewe));
                chk({tag, "_wdata"}, d0_bus_wdata, ewd);
            end
            tick();
        end
        gnt = 1'b0;
        rvalid = 1'b1; rdata = rd;
        mid();
        chk({tag, "_req_low"}, 32'(d0_bus_req), 32'd0);
        tick();
        rvalid = 1'b0; rdata = $urandom;
    endtask

    task automatic wait_rsp(input string tag, input bit sel, input int lat, input logic exp_err);
        bit seen = 1'b0;
        logic [31:0] exp_rd;
        for (int i = 0; i < 16 && !seen; i++) begin
            mid();
            if (sel ? d1_rsp_vld : d0_rsp_vld) seen = 1'b1;
            else tick();
        end
        chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        if (seen) begin
            chk({tag, "_latency"}, cyc - acc_cyc, lat);
            chk({tag, "_rdata"}, sel ? d1_rdata : d0_rdata, exp_rd);
            chk({tag, "_err"}, 32'(sel ? d1_err : d0_err), 32'(exp_err));
            tick();
            mid();
            chk({tag, "_pulse"}, 32'(sel ? d1_rsp_vld : d0_rsp_vld), 32'd0);
            chk({tag, "_idle_rdy"}, 32'(sel ? d1_req_rdy : d0_req_rdy), 32'd1);
            tick();
        end
    endtask

    initial begin
        // Reset
        tick();
        mid();
        chk("rst_req_rdy", 32'(d0_req_rdy), 32'd1);
        chk("rst_bus_req", 32'(d0_bus_req), 32'd0);
        chk("rst_rsp_vld", 32'(d0_rsp_vld), 32'd0);
        chk("rst_rdata", d0_rdata, 32'h0);
        chk("rst_d1_rdy", 32'(d1_req_rdy), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // SW aligned, single beat
        issue(1'b0, MEM_WR, LSU_W, 32'h0000_0100, 32'hDEAD_BEEF);
        bus_beat("sw", 32'h0000_0100, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0, 0);
        exp_q.push_back(32'h0);
        wait_rsp("sw", 1'b0, 3, 1'b0);

        // LB / LBU at byte 3
        issue(1'b0, MEM_RD, LSU_B, 32'h0000_0203, 32'h0);
        bus_beat("lb", 32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h8012_3456, 0);
        exp_q.push_back(32'hFFFF_FF80);
        wait_rsp("lb", 1'b0, 3, 1'b0);
        issue(1'b0, MEM_RD, LSU_BU, 32'h0000_0203, 32'h0);
        bus_beat("lbu", 32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h8012_3456, 0);
        exp_q.push_back(32'h0000_0080);
        wait_rsp("lbu", 1'b0, 3, 1'b0);

        // Aligned halfwords at offsets 2 and 1
        issue(1'b0, MEM_RD, LSU_HU, 32'h0000_0102, 32'h0);
        bus_beat("lhu", 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 32'h8765_4321, 0);
        exp_q.push_back(32'h0000_8765);
        wait_rsp("lhu", 1'b0, 3, 1'b0);
        issue(1'b0, MEM_RD, LSU_H, 32'h0000_0101, 32'h0);
        bus_beat("lh1", 32'h0000_0100, 4'b0110, 1'b0, 32'h0, 32'h00F0_0F00, 0);
        exp_q.push_back(32'hFFFF_F00F);
        wait_rsp("lh1", 1'b0, 3, 1'b0);

        // Split LH across words
        issue(1'b0, MEM_RD, LSU_H, 32'h0000_0103, 32'h0);
        bus_beat("lh_b0", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h1122_3344, 0);
        bus_beat("lh_b1", 32'h0000_0104, 4'b0001, 1'b0, 32'h0, 32'h5566_7788, 0);
        exp_q.push_back(32'hFFFF_8811);
        wait_rsp("lh_split", 1'b0, 5, 1'b0);

        // Split SW wrapping past the top of the address space
        issue(1'b0, MEM_WR, LSU_W, 32'hFFFF_FFFE, 32'hAABB_CCDD);
        bus_beat("sw_b0", 32'hFFFF_FFFC, 4'b1100, 1'b1, 32'hCCDD_0000, 32'h0, 0);
        bus_beat("sw_b1", 32'h0000_0000, 4'b0011, 1'b1, 32'h0000_AABB, 32'h0, 0);
        exp_q.push_back(32'h0);
        wait_rsp("sw_wrap", 1'b0, 5, 1'b0);

        // Grant withheld 5 cycles
        issue(1'b0, MEM_RD, LSU_W, 32'h0000_0104, 32'h0);
        bus_beat("lw_bp", 32'h0000_0104, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF, 5);
        exp_q.push_back(32'h1357_9BDF);
        wait_rsp("lw_bp", 1'b0, 8, 1'b0);

        // Misaligned LW rejected by the no-split instance
        issue(1'b1, MEM_RD, LSU_W, 32'h0000_0101, 32'h0);
        mid();
        chk("mis_no_bus_req", 32'({d1_bus_req, d1_rsp_vld}), 32'd0);
        tick();
        exp_q.push_back(32'h0);
        wait_rsp("mis_err", 1'b1, 2, 1'b1);

        // Reset during WAIT0, then a stray late rvalid
        issue(1'b0, MEM_RD, LSU_W, 32'h0000_0300, 32'h0);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #1;
        chk("abort_in_wait0", 32'(d0_state), 32'(WAIT0));
        rst_n = 1'b0;
        #1;
        chk("abort_state", 32'(d0_state), 32'(IDLE));
        chk("abort_outs", 32'({d0_bus_req, d0_rsp_vld, d0_req_rdy}), 32'b001);
        tick();
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("abort_quiet", 32'({d0_bus_req, d0_rsp_vld, d0_req_rdy}), 32'b001);
            tick();
        end

        // Normal operation after the abort
        issue(1'b0, MEM_RD, LSU_BU, 32'h0000_0203, 32'h0);
        bus_beat("post", 32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h8012_3456, 0);
        exp_q.push_back(32'h0000_0080);
        wait_rsp("post", 1'b0, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
